// File: rtl/ps2_pkg.sv
// PS/2 host transmitter shared definitions.
// FSM state encoding, keyboard command bytes, frame length.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_WAIT_IDLE
  } state_t;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_ACK         = 8'hFA;

  localparam int FRAME_BITS = 11;

endpackage

// File: rtl/ps2_sync.sv
// 2-flop synchroniser for the PS/2 clock/data pins plus clock fall detect.
// Ports: clk, rst (async low), ps2_clk_i/ps2_data_i in; clk_s, data_s, fall out.
module ps2_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_s,
  output logic data_s,
  output logic fall
);

  logic [1:0] cs;
  logic [1:0] ds;
  logic       clk_d;

  // Idle bus is pulled high, so reset to 1 to avoid a false fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs    <= 2'b11;
      ds    <= 2'b11;
      clk_d <= 1'b1;
    end else begin
      cs    <= {cs[0], ps2_clk_i};
      ds    <= {ds[0], ps2_data_i};
      clk_d <= cs[1];
    end
  end

  assign clk_s  = cs[1];
  assign data_s = ds[1];
  assign fall   = clk_d & ~cs[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with ACK check and timeout.
// Ports: tx_valid/tx_data/tx_ready in handshake, tx_done/tx_err pulses, busy,
// rx_inhibit, raw bus levels in, open-drain pull-low enables out.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  output logic       rx_inhibit,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int ICW =
    (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TCW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ICW-1:0] INH_LAST =
    ICW'(INHIBIT_CYCLES - 1);
  localparam logic [TCW-1:0] TMO_LAST =
    TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  state_t         state;
  state_t         state_n;
  logic [ICW-1:0] cnt;
  logic [TCW-1:0] tcnt;
  logic [3:0]     bitn;
  logic [9:0]     shreg;
  logic           dreg;
  logic           ack_ok;

  logic clk_s;
  logic data_s;
  logic fall;

  ps2_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .clk_s      (clk_s),
    .data_s     (data_s),
    .fall       (fall)
  );

  logic accept;
  logic inh_last;
  logic timed;
  logic tmo;
  logic bus_idle;
  logic step;

  assign accept   = tx_valid && (state == ST_IDLE);
  assign inh_last = (cnt == INH_LAST);
  assign timed    = (state == ST_REQ) ||
                    (state == ST_SHIFT) ||
                    (state == ST_WAIT_IDLE);
  assign tmo      = timed && (tcnt == TMO_LAST);
  assign bus_idle = clk_s && data_s;
  // REQ->SHIFT is fall 1; bitn is 0 there.
  assign step     = ((state == ST_REQ) ||
                     (state == ST_SHIFT)) &&
                    fall && !tmo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:
        if (tx_valid) state_n = ST_INHIBIT;
      ST_INHIBIT:
        if (inh_last) state_n = ST_REQ;
      ST_REQ:
        if (tmo)       state_n = ST_IDLE;
        else if (fall) state_n = ST_SHIFT;
      ST_SHIFT:
        if (tmo) state_n = ST_IDLE;
        else if (fall && bitn == LAST_BIT)
          state_n = ST_WAIT_IDLE;
      ST_WAIT_IDLE:
        if (tmo || bus_idle) state_n = ST_IDLE;
      default:
        state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_ready    = (state == ST_IDLE);
    busy        = (state != ST_IDLE);
    rx_inhibit  = (state != ST_IDLE);
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    tx_done     = 1'b0;
    tx_err      = tmo;
    unique case (state)
      ST_INHIBIT: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = inh_last;
      end
      ST_REQ:   ps2_data_oe = !tmo;
      ST_SHIFT: ps2_data_oe = dreg && !tmo;
      ST_WAIT_IDLE:
        if (!tmo && bus_idle) begin
          tx_done = ack_ok;
          tx_err  = !ack_ok;
        end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      tcnt   <= '0;
      bitn   <= '0;
      shreg  <= '0;
      dreg   <= 1'b0;
      ack_ok <= 1'b0;
    end else begin
      if (state == ST_INHIBIT) cnt <= cnt + ICW'(1);
      else                     cnt <= '0;

      if (!timed || state_n != state || fall)
        tcnt <= '0;
      else
        tcnt <= tcnt + TCW'(1);

      // Frame after data: parity (odd) then stop bit 1.
      if (accept) begin
        shreg  <= {1'b1, ~^tx_data, tx_data};
        bitn   <= '0;
        dreg   <= 1'b0;
        ack_ok <= 1'b0;
      end else if (step) begin
        bitn <= bitn + 4'd1;
        if (bitn == LAST_BIT) begin
          ack_ok <= ~data_s;
          dreg   <= 1'b0;
        end else begin
          dreg  <= ~shreg[0];
          shreg <= {1'b0, shreg[9:1]};
        end
      end
    end
  end

endmodule
